burst_fill_responder: RTL and testbench
=======================================

Name: burst_fill_responder

Overview:
- On-chip RAM-backed responder for the cache-side burst fill interface (req/rw/addr out, fill strobe plus 16-bit data stream in).
- Serves each read request as an 8-halfword burst, critical word first, wrapping within the 4-word cacheline.
- Accepts single 32-bit word writes as two halfword beats.
- Stands in for the SDRAM controller on boards without SDRAM and serves as the fill-protocol reference for cache benches.

Parameters:
- addrbits, 12, word-address width of the internal store (2**addrbits x 32-bit words, indexed by addr[addrbits+1:2]).
- latency, 4, cycles from request acceptance to fill assertion; legal range 2..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low.
- req  input  1  request from requester; held high until fill is seen.
- rw  input  1  1 = read burst, 0 = word write; sampled at acceptance.
- addr  input  32  byte address; bits [1:0] and bits above addrbits+1 ignored (aliasing).
- data_in  input  16  write halfwords: upper half at acceptance cycle, lower half on the next cycle.
- data_out  output  16  registered read burst data.
- fill  output  1  one-cycle strobe: first read beat valid, or write committed.
- busy  output  1  high from acceptance until return to IDLE.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; fill=0, busy=0, data_out=0; latency counter and beat counter cleared. Store contents are not cleared.
- Reset mid-operation: burst aborts with no further beats. A write whose lower half has not yet been captured is discarded.
- IDLE: busy=0 and data_out=0. If req==1 in cycle A, latch addr word index, rw and (if write) data_in as the upper half. Go to WAIT_LAT (read) or WR_LO (write); busy=1 from A+1.
- WAIT_LAT: count down from latency. Issue store reads early enough that the first beat is present in cycle A+latency.
- BURST: fill=1 in cycle A+latency only. Beats k=0..7 occupy cycles A+latency+k.
  - Beat k carries word ((addr[3:2] + k/2) mod 4) within the line addr[addrbits+1:4].
  - Even k carries bits [31:16]; odd k carries bits [15:0].
  - After beat 7, data_out=0 and the state returns to IDLE. A new req can be accepted in the cycle after beat 7.
  - req is ignored during the burst. Requester dropping req early does not shorten the burst.
- WR_LO (cycle A+1): capture data_in as the lower half and write the full 32-bit word to the store. Go to WR_ACK.
- WR_ACK (cycle A+2): fill=1 for one cycle. Go to HOLDOFF.
- HOLDOFF: busy=1. Wait for req==0, then go to IDLE. This prevents a still-high req from being re-accepted as a second write.
- Read-after-write: a read accepted in the cycle after HOLDOFF exit must return the newly written word.
- Latency outside 2..15: elaboration error.
- Address arithmetic: word wrap is modulo 4 within the line. No carry into addr bit 4.

Test Plan:
- Write 0xDEADBEEF to addr 0x104 (data_in 0xDEAD at A, 0xBEEF at A+1) -> fill pulse at A+2; busy high until req drops. Read 0x104 -> beats DEAD, BEEF, then words 0x108, 0x10C, 0x100.
- Preload 0x100..0x10C with 0x11112222, 0x33334444, 0x55556666, 0x77778888. Read req at 0x10C with latency=4 accepted at cycle 10 -> fill=1 only at cycle 14; data_out 7777, 8888, 1111, 2222, 3333, 4444, 5555, 6666 in cycles 14..21; 0 in cycle 22.
- Aliasing (addrbits=12): write 0xCAFEF00D to 0x40000104, then read 0x104 -> first beats CAFE, F00D.
- Back-to-back: read req held high through a burst, then a second read -> second acceptance no earlier than the cycle after beat 7; no overlap of beats.
- Write req held 5 cycles after fill -> exactly one store write; no second fill pulse; IDLE only after req==0.
- Reset asserted at beat 3 of a burst -> next cycle fill=0, busy=0, data_out=0. Write aborted at WR_LO -> store word unchanged on read-back.

Source files
------------

// File: rtl/burst_fill_responder.sv
// burst_fill_responder
//   RAM-backed responder for the cache-side burst fill interface. Each read
//   request returns an 8-halfword burst. The burst starts with the critical
//   word and wraps within the 4-word cacheline. Each write request stores one
//   32-bit word, delivered as two halfword beats.
//
// Parameters
//   addrbits : word-address width of the store (2**addrbits x 32-bit words)
//   latency  : cycles from request acceptance to fill assertion (2..15)
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous reset, active low
//   req      : request, held by the requester until fill is seen
//   rw       : 1 = read burst, 0 = word write (sampled at acceptance)
//   addr     : byte address; bits [1:0] and bits above addrbits+1 ignored
//   data_in  : write data; upper half at acceptance, lower half one cycle later
//   data_out : registered read burst data, 0 when no beat is present
//   fill     : one-cycle strobe, first read beat valid or write committed
//   busy     : high from the cycle after acceptance until back in IDLE
module burst_fill_responder #(
  parameter int addrbits = 12,
  parameter int latency  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        fill,
  output logic        busy
);

  if (latency < 2 || latency > 15) begin : g_latency_check
    $error("burst_fill_responder: latency must be within 2..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LAT,
    BURST,
    WR_LO,
    WR_ACK,
    HOLDOFF
  } state_t;

  state_t                state;
  logic [addrbits-3:0]   line;      // cacheline index, addr[addrbits+1:4]
  logic [1:0]            ptr;       // word within the line being fetched
  logic [3:0]            lat_cnt;
  logic [2:0]            beat;
  logic [15:0]           wr_hi;

  logic [31:0]           store [2**addrbits];
  logic [31:0]           store_q;
  logic [addrbits-1:0]   rd_index;

  // Address bits outside the word index are ignored on purpose (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:addrbits+2], addr[1:0]};

  // In IDLE the store is read straight from the request address. This lets
  // the first word be ready for latency == 2. Otherwise the latched line and
  // pointer are used.
  // NOTE: always_comb assigns rd_index on every path, so no latch is inferred.
  always_comb begin
    rd_index = (state == IDLE) ? addr[addrbits+1:2] : {line, ptr};
  end

  // The store is read synchronously every cycle. The write commits in WR_LO
  // only when reset is not asserted in that cycle. An aborted write therefore
  // leaves the old word in place.
  // NOTE: the store array has no reset. Its contents survive reset, and leaving
  // the reset off keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    store_q <= store[rd_index];
    if (reset && state == WR_LO) begin
      store[{line, ptr}] <= {wr_hi, data_in};
    end
  end

  // Read timing: store_q in cycle c holds the word that rd_index addressed in
  // cycle c-1. ptr is bumped as the first beat is launched and after every odd
  // beat. Each word is then sitting in store_q when its high half and its low
  // half are registered into data_out.
  // NOTE: all state here uses non-blocking assignments. Every register then
  // updates from pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fill     <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
      lat_cnt  <= '0;
      beat     <= '0;
      line     <= '0;
      ptr      <= '0;
      wr_hi    <= '0;
    end else begin
      fill <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            line <= addr[addrbits+1:4];
            ptr  <= addr[3:2];
            busy <= 1'b1;
            if (rw) begin
              lat_cnt <= 4'(latency - 2);
              state   <= WAIT_LAT;
            end else begin
              wr_hi <= data_in;
              state <= WR_LO;
            end
          end
        end

        WAIT_LAT: begin
          if (lat_cnt == 4'd0) begin
            fill     <= 1'b1;
            data_out <= store_q[31:16];
            ptr      <= ptr + 2'd1;
            beat     <= 3'd0;
            state    <= BURST;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        // req is not looked at here: the burst always runs all 8 beats.
        BURST: begin
          beat <= beat + 3'd1;
          if (beat == 3'd7) begin
            data_out <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (!beat[0]) begin
            data_out <= store_q[15:0];
          end else begin
            data_out <= store_q[31:16];
            ptr      <= ptr + 2'd1;
          end
        end

        WR_LO: begin
          fill  <= 1'b1;
          state <= WR_ACK;
        end

        WR_ACK: begin
          state <= HOLDOFF;
        end

        // Waiting for req to drop stops a still-high req from being taken as
        // a second write.
        HOLDOFF: begin
          if (!req) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_fill_responder.sv
// tb_burst_fill_responder
//   Self-checking bench for burst_fill_responder. It runs a table of directed
//   writes and reads with hand-computed burst contents. Hand-written sequences
//   cover reset during a burst and an aborted write. A randomized phase
//   follows. A word-array reference model supplies the expected fill timing,
//   busy window and critical-word-first burst ordering.
module tb_burst_fill_responder;

  localparam int AB  = 12;
  localparam int LAT = 4;

  logic        clk;
  logic        reset;
  logic        req;
  logic        rw;
  logic [31:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        fill;
  logic        busy;

  int n_cmp;
  int n_err;

  logic [31:0] model [2**AB];

  burst_fill_responder #(
    .addrbits (AB),
    .latency  (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rw       (rw),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .fill     (fill),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AB-1:0] word_index(input logic [31:0] a);
    return a[AB+1:2];
  endfunction

  // Beat k: word (offset + k/2) mod 4 of the line. Even k gives the high
  // half and odd k the low half.
  function automatic logic [15:0] beat_val(input logic [31:0] a, input int k);
    int          w;
    logic [31:0] word;
    w    = (int'(a[3:2]) + k / 2) % 4;
    word = model[{a[AB+1:4], 2'(w)}];
    return (k % 2 == 0) ? word[31:16] : word[15:0];
  endfunction

  // Starts at a negedge in the acceptance cycle A. Returns at the negedge of
  // the first cycle back in IDLE.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int hold);
    int drop_cyc;
    int low_cyc;
    req     = 1'b1;
    rw      = 1'b0;
    addr    = a;
    data_in = d[31:16];
    @(negedge clk);                        // A+1
    check("wr_busy_a1", 32'(busy), 32'd1);
    check("wr_fill_a1", 32'(fill), 32'd0);
    data_in = d[15:0];
    addr    = $urandom;
    @(negedge clk);                        // A+2
    check("wr_fill_a2", 32'(fill), 32'd1);
    check("wr_busy_a2", 32'(busy), 32'd1);
    model[word_index(a)] = d;
    data_in = 16'($urandom);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      check("wr_hold_fill", 32'(fill), 32'd0);
      check("wr_hold_busy", 32'(busy), 32'd1);
      data_in = 16'($urandom);
      rw      = 1'($urandom);
      addr    = $urandom;
    end
    req      = 1'b0;
    drop_cyc = 2 + hold;
    low_cyc  = ((drop_cyc > 3) ? drop_cyc : 3) + 1;
    for (int c = drop_cyc + 1; c <= low_cyc; c++) begin
      @(negedge clk);
      check("wr_tail_fill", 32'(fill), 32'd0);
      check("wr_tail_busy", 32'(busy), (c < low_cyc) ? 32'd1 : 32'd0);
    end
  endtask

  // Starts at a negedge in cycle A. req drops after cycle drop_after unless
  // keep is set. Returns at the negedge of cycle A+LAT+8 (IDLE).
  task automatic do_read(input logic [31:0] a, input int drop_after, input bit keep,
                         output logic [7:0][15:0] got);
    logic [15:0] exp_d;
    got     = '0;
    req     = 1'b1;
    rw      = 1'b1;
    addr    = a;
    data_in = 16'($urandom);
    for (int c = 1; c <= LAT + 8; c++) begin
      @(negedge clk);
      exp_d = (c >= LAT && c <= LAT + 7) ? beat_val(a, c - LAT) : 16'h0000;
      check("rd_fill", 32'(fill), (c == LAT) ? 32'd1 : 32'd0);
      check("rd_busy", 32'(busy), (c <= LAT + 7) ? 32'd1 : 32'd0);
      check("rd_data", 32'(data_out), 32'(exp_d));
      if (c >= LAT && c <= LAT + 7) got[c - LAT] = data_out;
      if (!keep && c == drop_after) req = 1'b0;
      if (c < LAT + 8) begin
        addr    = $urandom;
        rw      = 1'($urandom);
        data_in = 16'($urandom);
      end
    end
    if (keep) rw = 1'b1;
  endtask

  typedef struct packed {
    logic             wr;
    logic [31:0]      a;
    logic [31:0]      d;
    logic [3:0]       hold;
    logic             keep;
    logic [7:0][15:0] exp;
  } vec_t;

  // exp lists beats in order, beat 0 first.
  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input int hold, input logic keep, input logic [127:0] exp);
    vec_t v;
    v.wr   = wr;
    v.a    = a;
    v.d    = d;
    v.hold = 4'(hold);
    v.keep = keep;
    for (int k = 0; k < 8; k++) v.exp[k] = exp[127 - 16 * k -: 16];
    return v;
  endfunction

  initial begin
    vec_t             vecs [12];
    logic [7:0][15:0] got;
    logic [31:0]      ra;
    logic [31:0]      old_word;
    bit               keep;

    n_cmp = 0;
    n_err = 0;

    vecs[0]  = mk(1'b1, 32'h0000_0100, 32'h1111_2222, 1, 1'b0, '0);
    vecs[1]  = mk(1'b1, 32'h0000_0104, 32'h3333_4444, 0, 1'b0, '0);
    vecs[2]  = mk(1'b1, 32'h0000_0108, 32'h5555_6666, 2, 1'b0, '0);
    vecs[3]  = mk(1'b1, 32'h0000_010C, 32'h7777_8888, 1, 1'b0, '0);
    vecs[4]  = mk(1'b0, 32'h0000_010C, '0, 0, 1'b0,
                  {16'h7777, 16'h8888, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666});
    vecs[5]  = mk(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 5, 1'b0, '0);
    vecs[6]  = mk(1'b0, 32'h0000_0104, '0, 0, 1'b0,
                  {16'hDEAD, 16'hBEEF, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h1111, 16'h2222});
    vecs[7]  = mk(1'b1, 32'h4000_0104, 32'hCAFE_F00D, 1, 1'b0, '0);
    vecs[8]  = mk(1'b0, 32'h0000_0104, '0, 0, 1'b0,
                  {16'hCAFE, 16'hF00D, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h1111, 16'h2222});
    vecs[9]  = mk(1'b0, 32'h0000_0107, '0, 0, 1'b0,
                  {16'hCAFE, 16'hF00D, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h1111, 16'h2222});
    vecs[10] = mk(1'b0, 32'h0000_0108, '0, 0, 1'b1,
                  {16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h1111, 16'h2222, 16'hCAFE, 16'hF00D});
    vecs[11] = mk(1'b0, 32'h8000_0100, '0, 0, 1'b0,
                  {16'h1111, 16'h2222, 16'hCAFE, 16'hF00D, 16'h5555, 16'h6666, 16'h7777, 16'h8888});

    reset   = 1'b0;
    req     = 1'b0;
    rw      = 1'b0;
    addr    = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_fill", 32'(fill), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Directed table. Entry 10 keeps req high into entry 11 (back-to-back).
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].a, vecs[i].d, int'(vecs[i].hold));
      end else begin
        do_read(vecs[i].a, 1, vecs[i].keep, got);
        for (int k = 0; k < 8; k++) check($sformatf("table%0d_beat%0d", i, k),
                                          32'(got[k]), 32'(vecs[i].exp[k]));
      end
    end
    req = 1'b0;
    @(negedge clk);

    // Reset asserted while beat 3 of a burst is on the bus.
    ra   = 32'h0000_0108;
    req  = 1'b1;
    rw   = 1'b1;
    addr = ra;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
    end
    check("rst_mid_beat3", 32'(data_out), 32'(beat_val(ra, 3)));
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_fill", 32'(fill), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_data", 32'(data_out), 32'd0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_after_busy", 32'(busy), 32'd0);
      check("rst_after_data", 32'(data_out), 32'd0);
    end

    // Write aborted by reset while in WR_LO. The stored word must survive.
    ra       = 32'h0000_0104;
    old_word = model[word_index(ra)];
    req      = 1'b1;
    rw       = 1'b0;
    addr     = ra;
    data_in  = 16'h0BAD;
    @(negedge clk);
    data_in = 16'hF00F;
    reset   = 1'b0;
    req     = 1'b0;
    @(negedge clk);
    check("abort_fill", 32'(fill), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    do_read(ra, 2, 1'b0, got);
    check("abort_keep_word", {got[0], got[1]}, old_word);

    // Randomized phase over a 64-word window, starting with a preload.
    for (int w = 0; w < 64; w++) begin
      do_write({18'($urandom), 12'(12'h080 + w), 2'($urandom)}, $urandom, $urandom_range(0, 3));
    end
    for (int n = 0; n < 80; n++) begin
      ra = {18'($urandom), 12'(12'h080 + $urandom_range(0, 63)), 2'($urandom)};
      if ($urandom_range(0, 9) < 4) begin
        do_write(ra, $urandom, $urandom_range(0, 4));
      end else begin
        keep = ($urandom_range(0, 3) == 0);
        do_read(ra, $urandom_range(1, LAT + 8), keep, got);
      end
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
